// File: rtl/counter_pkg.sv
// Shared constants and state encoding for the range counter family.
package counter_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 8;
  localparam int unsigned CNT_HI_DEF    = 40;
  localparam int unsigned CNT_LO_DEF    = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_e;

endpackage

// File: rtl/counter_range_chk.sv
// Combinational check that a value lies in the inclusive range [LO, HI].
module counter_range_chk
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH_DEF,
  parameter int unsigned HI    = CNT_HI_DEF,
  parameter int unsigned LO    = CNT_LO_DEF
) (
  input  logic [WIDTH-1:0] i_value,
  output logic             o_in_range_c
);

  localparam logic [WIDTH-1:0] L_HI = WIDTH'(HI);
  localparam logic [WIDTH-1:0] L_LO = WIDTH'(LO);

  assign o_in_range_c = (i_value >= L_LO) && (i_value <= L_HI);

endmodule

// File: rtl/counter_40_to_10_down.sv
// Loadable HI-to-LO down counter with start/stop FSM, periodic or one-shot mode.
// Optional load handshake enabled by defining COUNTER_DOWN_LOAD_EN.
module counter_40_to_10_down
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = CNT_WIDTH_DEF,
  parameter int unsigned HI       = CNT_HI_DEF,
  parameter int unsigned LO       = CNT_LO_DEF,
  parameter bit          PERIODIC = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_stop,
`ifdef COUNTER_DOWN_LOAD_EN
  input  logic             i_load_valid,
  input  logic [WIDTH-1:0] i_load_data,
  output logic             o_load_ready,
`endif
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_busy,
  output logic             o_err
);

  localparam logic [1:0]       S_IDLE = 2'(IDLE);
  localparam logic [1:0]       S_RUN  = 2'(RUN);
  localparam logic [1:0]       S_DONE = 2'(DONE);
  localparam logic [WIDTH-1:0] L_HI   = WIDTH'(HI);
  localparam logic [WIDTH-1:0] L_LO   = WIDTH'(LO);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_busy;
  logic             r_err;

  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_tc_nxt;
  logic             w_err_nxt;
  logic             w_cnt_ok;

  counter_range_chk #(.WIDTH(WIDTH), .HI(HI), .LO(LO)) u_cnt_chk (
    .i_value      (r_count),
    .o_in_range_c (w_cnt_ok)
  );

`ifdef COUNTER_DOWN_LOAD_EN
  logic r_load_ready;
  logic w_load_ok;
  logic w_load_xfer;

  counter_range_chk #(.WIDTH(WIDTH), .HI(HI), .LO(LO)) u_load_chk (
    .i_value      (i_load_data),
    .o_in_range_c (w_load_ok)
  );

  assign w_load_xfer  = i_load_valid && r_load_ready;
  assign o_load_ready = r_load_ready;
`endif

  // Next-state, next-count and flag logic; stop dominates, range repair is last.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    w_err_nxt   = r_err;

    if (i_stop) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = L_HI;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (i_en) begin
            if (r_count == L_LO) begin
              w_tc_nxt = 1'b1;
              if (PERIODIC) begin
                w_count_nxt = L_HI;
              end else begin
                w_state_nxt = S_DONE;
              end
            end else begin
              w_count_nxt = r_count - WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          if (i_start) begin
            w_state_nxt = S_RUN;
            w_count_nxt = L_HI;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_count_nxt = L_HI;
        end
      endcase
`ifdef COUNTER_DOWN_LOAD_EN
      if (w_load_xfer) begin
        if (w_load_ok) begin
          w_count_nxt = i_load_data;
        end else begin
          w_count_nxt = L_HI;
          w_err_nxt   = 1'b1;
        end
      end
`endif
    end

    if (!w_cnt_ok) begin
      w_count_nxt = L_HI;
      w_err_nxt   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_count <= L_HI;
      r_tc    <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_err   <= w_err_nxt;
    end
  end

`ifdef COUNTER_DOWN_LOAD_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_load_ready <= 1'b1;
    else          r_load_ready <= (w_state_nxt != S_RUN);
  end
`endif

  assign o_count = r_count;
  assign o_tc    = r_tc;
  assign o_busy  = r_busy;
  assign o_err   = r_err;

endmodule

// File: tb/tb_counter_40_to_10_down.sv
// Directed scoreboard bench: periodic instance (dut) and one-shot instance (dut1).
module tb_counter_40_to_10_down;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b1;
  logic       en     = 1'b0;
  logic       start  = 1'b0;
  logic       stop   = 1'b0;
  logic       start1 = 1'b0;
  logic       stop1  = 1'b0;
  logic [7:0] count, count1;
  logic       tc, busy, err, tc1, busy1, err1;
`ifdef COUNTER_DOWN_LOAD_EN
  logic       load_valid  = 1'b0;
  logic [7:0] load_data   = 8'd0;
  logic       load_ready;
  logic       load_valid1 = 1'b0;
  logic [7:0] load_data1  = 8'd0;
  logic       load_ready1;
`endif

  always #5 clk = ~clk;

  counter_40_to_10_down #(.WIDTH(8), .HI(40), .LO(10), .PERIODIC(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start), .i_stop(stop),
`ifdef COUNTER_DOWN_LOAD_EN
    .i_load_valid(load_valid), .i_load_data(load_data), .o_load_ready(load_ready),
`endif
    .o_count(count), .o_tc(tc), .o_busy(busy), .o_err(err)
  );

  counter_40_to_10_down #(.WIDTH(8), .HI(40), .LO(10), .PERIODIC(1'b0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start1), .i_stop(stop1),
`ifdef COUNTER_DOWN_LOAD_EN
    .i_load_valid(load_valid1), .i_load_data(load_data1), .o_load_ready(load_ready1),
`endif
    .o_count(count1), .o_tc(tc1), .o_busy(busy1), .o_err(err1)
  );

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t x;
    n_chk++;
    if (sb.size() == 0) begin
      $error("FAIL sb_empty: observed %0d with no expected value queued", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", x.tag, obs, x.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int t;

    // Async reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    push("rst_count", 40); push("rst_tc", 0); push("rst_busy", 0); push("rst_err", 0);
    pop_cmp(32'(count)); pop_cmp(32'(tc)); pop_cmp(32'(busy)); pop_cmp(32'(err));
`ifdef COUNTER_DOWN_LOAD_EN
    push("rst_load_ready", 1); pop_cmp(32'(load_ready));
`endif
    tick();
    rst_n = 1'b1;
    en    = 1'b1;

    // Start, then two full periodic spans
    start = 1'b1;
    push("start_busy", 1); push("start_count", 40);
    tick();
    start = 1'b0;
    pop_cmp(32'(busy)); pop_cmp(32'(count));
`ifdef COUNTER_DOWN_LOAD_EN
    push("run_load_ready", 0); pop_cmp(32'(load_ready));
`endif
    c = 40;
    for (int i = 0; i < 62; i++) begin
      if (c == 10) begin c = 40; t = 1; end
      else begin c = c - 1; t = 0; end
      push("per_count", 32'(c)); push("per_tc", 32'(t));
      tick();
      pop_cmp(32'(count)); pop_cmp(32'(tc));
    end

    // en toggling: count moves only on enabled edges
    for (int i = 0; i < 8; i++) begin
      en = i[0];
      if (en) c = c - 1;
      push("en_count", 32'(c));
      tick();
      pop_cmp(32'(count));
    end
    en = 1'b1;

    // Simultaneous start and stop: stop wins
    start = 1'b1; stop = 1'b1;
    push("stopstart_count", 40); push("stopstart_busy", 0);
    tick();
    start = 1'b0; stop = 1'b0;
    pop_cmp(32'(count)); pop_cmp(32'(busy));
    push("idle_hold_count", 40);
    tick();
    pop_cmp(32'(count));

    // Out-of-range repair in IDLE (below LO)
    force dut.r_count = 8'd5;
    #1 release dut.r_count;
    push("lo_fix_count", 40); push("lo_fix_err", 1);
    tick();
    pop_cmp(32'(count)); pop_cmp(32'(err));

    // Out-of-range repair in RUN (above HI)
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    force dut.r_count = 8'd60;
    #1 release dut.r_count;
    push("hi_fix_count", 40); push("hi_fix_err", 1); push("hi_fix_busy", 1);
    tick();
    pop_cmp(32'(count)); pop_cmp(32'(err)); pop_cmp(32'(busy));
    stop = 1'b1;
    push("err_sticky", 1);
    tick();
    stop = 1'b0;
    pop_cmp(32'(err));

    // Reset clears err; then reset mid-run at 17
    rst_n = 1'b0;
    #1;
    push("rst_clear_err", 0); pop_cmp(32'(err));
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 23; i++) tick();
    push("pre_rst_count", 17); pop_cmp(32'(count));
    #2 rst_n = 1'b0;
    #1;
    push("midrst_count", 40); push("midrst_tc", 0); push("midrst_busy", 0); push("midrst_err", 0);
    pop_cmp(32'(count)); pop_cmp(32'(tc)); pop_cmp(32'(busy)); pop_cmp(32'(err));
    tick();
    push("midrst_hold_tc", 0); pop_cmp(32'(tc));
    rst_n = 1'b1;

    // One-shot instance: 40 down to 10, single tc, then DONE
    start1 = 1'b1;
    push("os_start_count", 40); push("os_start_busy", 1);
    tick();
    start1 = 1'b0;
    pop_cmp(32'(count1)); pop_cmp(32'(busy1));
    for (int i = 1; i <= 30; i++) begin
      push("os_count", 32'(40 - i)); push("os_tc", 0);
      tick();
      pop_cmp(32'(count1)); pop_cmp(32'(tc1));
    end
    push("os_done_count", 10); push("os_done_tc", 1); push("os_done_busy", 0);
    tick();
    pop_cmp(32'(count1)); pop_cmp(32'(tc1)); pop_cmp(32'(busy1));
    push("os_hold_count", 10); push("os_hold_tc", 0);
    tick();
    pop_cmp(32'(count1)); pop_cmp(32'(tc1));
    start1 = 1'b1;
    push("os_restart_count", 40); push("os_restart_busy", 1);
    tick();
    start1 = 1'b0;
    pop_cmp(32'(count1)); pop_cmp(32'(busy1));

`ifdef COUNTER_DOWN_LOAD_EN
    // Load 25 with start from IDLE
    load_valid = 1'b1; load_data = 8'd25; start = 1'b1;
    push("load_count", 25); push("load_busy", 1); push("load_ready_run", 0);
    tick();
    load_valid = 1'b0; start = 1'b0;
    pop_cmp(32'(count)); pop_cmp(32'(busy)); pop_cmp(32'(load_ready));
    push("load_dec1", 24); tick(); pop_cmp(32'(count));
    push("load_dec2", 23); tick(); pop_cmp(32'(count));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    // Out-of-range load
    load_valid = 1'b1; load_data = 8'd50;
    push("badload_count", 40); push("badload_err", 1); push("badload_busy", 0);
    tick();
    load_valid = 1'b0;
    pop_cmp(32'(count)); pop_cmp(32'(err)); pop_cmp(32'(busy));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_40_to_10_down.md
# counter_40_to_10_down

Loadable range down counter: the down-counting counterpart of the team's 10-to-40 up counter. It counts from HI down to LO under a start/stop control FSM and supports periodic reload or one-shot modes. A registered terminal-count pulse marks each completed span. It also self-corrects any out-of-range value. It serves as a timeout/interval timer alongside the up counters.

## Interface
- WIDTH, 8: counter width in bits.
- HI, 40: start/reload value; requires HI > LO and HI < 2^WIDTH.
- LO, 10: terminal value.
- PERIODIC, 1: 1 = reload HI after LO; 0 = one-shot, stop at LO.
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable; decrement only when high in RUN.
- start  input  1  pulse: begin counting.
- stop  input  1  pulse: abort and return to IDLE.
- count  output  WIDTH  current value.
- tc  output  1  one-cycle registered terminal-count pulse.
- busy  output  1  high in RUN.
- err  output  1  sticky out-of-range flag.
- load_valid  input  1  load request (COUNTER_DOWN_LOAD_EN only).
- load_data  input  WIDTH  load value (COUNTER_DOWN_LOAD_EN only).
- load_ready  output  1  load can be accepted (COUNTER_DOWN_LOAD_EN only).

## Operation
- Reset state (async, rst low): state IDLE, count=HI, tc=0, busy=0, err=0, load_ready=1.
- States:
  - IDLE: count held. start → RUN.
  - RUN: when en=1, count decrements by 1 per edge.
    - Decrement from count==LO, PERIODIC=1: count←HI, tc=1, stay RUN.
    - Decrement from count==LO, PERIODIC=0: count holds LO, tc=1, → DONE.
    - en=0: count holds.
  - DONE: count holds LO. start → RUN with count←HI.
- stop from any state: → IDLE with count←HI. Simultaneous start and stop: stop wins.
- start in RUN: ignored.
- Self-correction: count >HI or <LO at any edge (any state, regardless of en) → count←HI and err←1. err clears only on reset.
- Arithmetic: unsigned WIDTH bits; no wrap below LO ever reaches count.

## Timing
- start sampled at edge k: busy=1 after edge k. First decrement occurs at edge k+1 if en=1.
- Full span (PERIODIC=1, en steady high): HI−LO+1 cycles between tc pulses.
- tc: registered, high for exactly one cycle, coincident with count showing HI (periodic) or the first DONE cycle.
- busy: registered, equals (state==RUN).
- Load handshake: transfer when load_valid && load_ready. load_ready=1 in IDLE/DONE, 0 in RUN.
  - In-range load_data: count←load_data on that edge.
  - Out-of-range load_data: count←HI, err←1.
  - Load with start in same cycle: loaded value used; → RUN; first decrement at next enabled edge.
  - Load in DONE without start: stays DONE with loaded count.
  - Load with stop in same cycle: stop wins, count←HI.
- rst mid-run: immediate return to reset values, with no tc.

## Configuration
- COUNTER_DOWN_LOAD_EN defined: load_valid/load_data/load_ready ports and the handshake are present.
- COUNTER_DOWN_LOAD_EN undefined: load ports are absent, and every run starts from HI. All other behaviour is identical.

## Structure
- Package counter_pkg:
  - state enum (IDLE, RUN, DONE);
  - default HI/LO/WIDTH constants shared with the up counters.
- Sub-module counter_range_chk: combinational in-range check, parameterized HI/LO. Used for self-correction and for load validation.

## Test plan
- Reset, start, en high: count 40,39,…,10,40. tc high once per 31-cycle period, aligned with 40.
- PERIODIC=0: count reaches 10, then holds 10. tc pulses once, busy drops. Next start reloads 40.
- en toggling 1/0 in RUN: count changes only on en=1 edges. stop with start in same cycle → IDLE, count=40.
- Force count to 5 and to 60 via hierarchical deposit: next edge count=40, err=1 sticky until rst.
- Load handshake, macro defined:
  - load 25 in IDLE with start: count 25,24,…; load_ready=0 in RUN.
  - load 50: count=40, err=1.
- rst asserted mid-count at 17: outputs return to reset values immediately, with no tc.
